// File: rtl/laser_stream_driver.sv
// ---------------------------------------------------------------------------
// laser_stream_driver
//
// Front end for the LASER circle-placement core. It holds a NUM_POINTS-entry
// target set, resets the core, and streams the points into it one per cycle.
// It then waits for the core's done flag, captures both circle centres, and
// scores them: the score is the number of points that lie inside either
// circle (dx^2 + dy^2 <= 16).
//
// Optional feature macro: LASER_DRV_TIMEOUT_EN
//   defined   : a 16-bit watchdog limits WAIT to TIMEOUT_CYC cycles; on expiry
//               the run aborts with res_timeout=1, res_valid=1, score=0 and
//               the captured centres set to 0.
//   undefined : no watchdog is built, WAIT lasts until done, res_timeout=0.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   ld_valid, ld_idx, ld_x, ld_y point write port (IDLE only)
//   start                        run request (IDLE only)
//   lsr_rst                      active-high reset to the core
//   x, y                         point stream to the core
//   c1x, c1y, c2x, c2y, done     core result centres and completion flag
//   busy                         high in every state except IDLE
//   res_valid, res_timeout       result available / last run aborted
//   score                        covered-point count
//   cap_c1x .. cap_c2y           captured centres
// ---------------------------------------------------------------------------
module laser_stream_driver #(
    parameter int NUM_POINTS  = 40,
    parameter int IDX_W       = 6,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [3:0]       ld_x,
    input  logic [3:0]       ld_y,
    input  logic             start,
    output logic             lsr_rst,
    output logic [3:0]       x,
    output logic [3:0]       y,
    input  logic [3:0]       c1x,
    input  logic [3:0]       c1y,
    input  logic [3:0]       c2x,
    input  logic [3:0]       c2y,
    input  logic             done,
    output logic             busy,
    output logic             res_valid,
    output logic             res_timeout,
    output logic [5:0]       score,
    output logic [3:0]       cap_c1x,
    output logic [3:0]       cap_c1y,
    output logic [3:0]       cap_c2x,
    output logic [3:0]       cap_c2y
);

    // state | meaning
    // IDLE  | accept point writes, wait for start
    // RSTC  | one cycle with the core held in reset, point 0 already on x/y
    // SEND  | NUM_POINTS cycles, point k on x/y in SEND cycle k
    // WAIT  | wait for done (optionally bounded by the watchdog)
    // SCORE | NUM_POINTS cycles, one point tested against both centres per cycle
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RSTC  = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_SCORE = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_POINTS - 1);
    localparam logic [5:0]       SCORE_MAX = 6'(NUM_POINTS);

    // Elaboration-time marker: a watchdog limit outside 1..65536 cannot be
    // represented by the 16-bit counter.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_timeout_cfg_out_of_range
    end

    // Coverage test for radius 4 written as a per-dx limit on dy, which is
    // cheaper than squaring and equivalent for integer offsets.
    function automatic logic covers(input logic [3:0] px, input logic [3:0] py,
                                    input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic       hit;
        dx = (px >= cx) ? (px - cx) : (cx - px);
        dy = (py >= cy) ? (py - cy) : (cy - py);
        case (dx)
            4'd0:       hit = (dy <= 4'd4);
            4'd1, 4'd2: hit = (dy <= 4'd3);
            4'd3:       hit = (dy <= 4'd2);
            4'd4:       hit = (dy == 4'd0);
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

    logic [7:0]       mem_q [NUM_POINTS];

    logic [2:0]       state_q,     state_d;
    logic [IDX_W-1:0] cnt_q,       cnt_d;
    logic             lsr_rst_q,   lsr_rst_d;
    logic [3:0]       x_q,         x_d;
    logic [3:0]       y_q,         y_d;
    logic             busy_q,      busy_d;
    logic             res_valid_q, res_valid_d;
    logic [5:0]       score_q,     score_d;
    logic [3:0]       cap_c1x_q,   cap_c1x_d;
    logic [3:0]       cap_c1y_q,   cap_c1y_d;
    logic [3:0]       cap_c2x_q,   cap_c2x_d;
    logic [3:0]       cap_c2y_q,   cap_c2y_d;

`ifdef LASER_DRV_TIMEOUT_EN
    localparam logic [15:0] WDOG_LOAD = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wdog_q, wdog_d;
    logic        res_timeout_q, res_timeout_d;
`endif

    logic             ld_wr_ok;
    logic [IDX_W-1:0] nxt_idx;
    logic [7:0]       pt0;
    logic [7:0]       score_pt;
    logic             score_hit;

    assign ld_wr_ok = (state_q == ST_IDLE) && ld_valid && (ld_idx <= LAST_IDX);
    assign nxt_idx  = cnt_q + 1'b1;

    // A write to slot 0 on the start edge must reach the stream in RSTC,
    // so forward it around the memory.
    assign pt0 = (ld_wr_ok && (ld_idx == '0)) ? {ld_x, ld_y} : mem_q[0];

    assign score_pt  = mem_q[cnt_q];
    assign score_hit = covers(score_pt[7:4], score_pt[3:0], cap_c1x_q, cap_c1y_q) |
                       covers(score_pt[7:4], score_pt[3:0], cap_c2x_q, cap_c2y_q);

    // Point memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (ld_wr_ok) begin
            mem_q[ld_idx] <= {ld_x, ld_y};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lsr_rst_d   = 1'b0;
        x_d         = 4'd0;
        y_d         = 4'd0;
        res_valid_d = res_valid_q;
        score_d     = score_q;
        cap_c1x_d   = cap_c1x_q;
        cap_c1y_d   = cap_c1y_q;
        cap_c2x_d   = cap_c2x_q;
        cap_c2y_d   = cap_c2y_q;
`ifdef LASER_DRV_TIMEOUT_EN
        wdog_d        = wdog_q;
        res_timeout_d = res_timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RSTC;
                    lsr_rst_d   = 1'b1;
                    res_valid_d = 1'b0;
                    score_d     = 6'd0;
                    {x_d, y_d}  = pt0;
`ifdef LASER_DRV_TIMEOUT_EN
                    res_timeout_d = 1'b0;
`endif
                end
            end

            ST_RSTC: begin
                state_d    = ST_SEND;
                cnt_d      = '0;
                {x_d, y_d} = mem_q[0];
            end

            ST_SEND: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
`ifdef LASER_DRV_TIMEOUT_EN
                    wdog_d  = WDOG_LOAD;
`endif
                end else begin
                    cnt_d      = nxt_idx;
                    {x_d, y_d} = mem_q[nxt_idx];
                end
            end

            ST_WAIT: begin
                if (done) begin
                    state_d   = ST_SCORE;
                    cnt_d     = '0;
                    cap_c1x_d = c1x;
                    cap_c1y_d = c1y;
                    cap_c2x_d = c2x;
                    cap_c2y_d = c2y;
                end
`ifdef LASER_DRV_TIMEOUT_EN
                else if (wdog_q == 16'd0) begin
                    state_d       = ST_IDLE;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    score_d       = 6'd0;
                    cap_c1x_d     = 4'd0;
                    cap_c1y_d     = 4'd0;
                    cap_c2x_d     = 4'd0;
                    cap_c2y_d     = 4'd0;
                end else begin
                    wdog_d = wdog_q - 16'd1;
                end
`endif
            end

            ST_SCORE: begin
                if (score_hit && (score_q != SCORE_MAX)) begin
                    score_d = score_q + 6'd1;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    res_valid_d = 1'b1;
                end else begin
                    cnt_d = nxt_idx;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lsr_rst_q   <= 1'b1;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            score_q     <= 6'd0;
            cap_c1x_q   <= 4'd0;
            cap_c1y_q   <= 4'd0;
            cap_c2x_q   <= 4'd0;
            cap_c2y_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lsr_rst_q   <= lsr_rst_d;
            x_q         <= x_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            score_q     <= score_d;
            cap_c1x_q   <= cap_c1x_d;
            cap_c1y_q   <= cap_c1y_d;
            cap_c2x_q   <= cap_c2x_d;
            cap_c2y_q   <= cap_c2y_d;
        end
    end

`ifdef LASER_DRV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q        <= 16'd0;
            res_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign res_timeout = res_timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    assign lsr_rst   = lsr_rst_q;
    assign x         = x_q;
    assign y         = y_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign score     = score_q;
    assign cap_c1x   = cap_c1x_q;
    assign cap_c1y   = cap_c1y_q;
    assign cap_c2x   = cap_c2x_q;
    assign cap_c2y   = cap_c2y_q;

endmodule

// File: tb/tb_laser_stream_driver.sv
// ---------------------------------------------------------------------------
// tb_laser_stream_driver
//
// Randomised self-checking bench. The reference keeps its own copy of the
// point set and computes the score directly from dx^2 + dy^2 <= 16.
// Optional feature macro: LASER_DRV_TIMEOUT_EN (selects the watchdog test).
// ---------------------------------------------------------------------------
module tb_laser_stream_driver;

    localparam int NP = 40;
`ifdef LASER_DRV_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 4096;
`endif

    logic       clk;
    logic       rst_n;
    logic       ld_valid;
    logic [5:0] ld_idx;
    logic [3:0] ld_x, ld_y;
    logic       start;
    logic       lsr_rst;
    logic [3:0] x, y;
    logic [3:0] c1x, c1y, c2x, c2y;
    logic       done;
    logic       busy, res_valid, res_timeout;
    logic [5:0] score;
    logic [3:0] cap_c1x, cap_c1y, cap_c2x, cap_c2y;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] mx [NP];
    logic [3:0] my [NP];

    laser_stream_driver #(
        .NUM_POINTS (NP),
        .IDX_W      (6),
        .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_idx     (ld_idx),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .start      (start),
        .lsr_rst    (lsr_rst),
        .x          (x),
        .y          (y),
        .c1x        (c1x),
        .c1y        (c1y),
        .c2x        (c2x),
        .c2y        (c2y),
        .done       (done),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_timeout(res_timeout),
        .score      (score),
        .cap_c1x    (cap_c1x),
        .cap_c1y    (cap_c1y),
        .cap_c2x    (cap_c2x),
        .cap_c2y    (cap_c2y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int ref_score(input int ax, input int ay, input int bx, input int by);
        int cnt = 0;
        for (int i = 0; i < NP; i++) begin
            int px = int'(mx[i]);
            int py = int'(my[i]);
            bit in_a = ((px - ax) * (px - ax) + (py - ay) * (py - ay)) <= 16;
            bit in_b = ((px - bx) * (px - bx) + (py - by) * (py - by)) <= 16;
            if (in_a || in_b) cnt++;
        end
        return (cnt > NP) ? NP : cnt;
    endfunction

    task automatic load_point(input int idx, input int px, input int py);
        ld_valid = 1'b1;
        ld_idx   = 6'(idx);
        ld_x     = 4'(px);
        ld_y     = 4'(py);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        if (idx < NP) begin
            mx[idx] = 4'(px);
            my[idx] = 4'(py);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lsr_rst"}, lsr_rst, 1);
        check({tag, "_xy"}, {x, y}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_timeout"}, res_timeout, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_caps"}, {cap_c1x, cap_c1y, cap_c2x, cap_c2y}, 0);
    endtask

    // One full run. Also injects a dropped write, a stray start and an early
    // done while the driver is busy; all must be ignored.
    task automatic run_once(input int ax, input int ay, input int bx, input int by,
                            input int lat);
        int         exp;
        logic [3:0] keep_x0, keep_y0;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        ld_valid = 1'b0;
        check("rstc_lsr_rst", lsr_rst, 1);
        check("rstc_busy", busy, 1);
        check("rstc_xy", {x, y}, {mx[0], my[0]});
        check("start_clears_valid", res_valid, 0);
        check("start_clears_timeout", res_timeout, 0);
        check("start_clears_score", score, 0);
        keep_x0 = mx[0];
        keep_y0 = my[0];
        for (int k = 0; k < NP; k++) begin
            @(posedge clk); #1;
            check("send_lsr_rst", lsr_rst, 0);
            check("send_xy", {x, y}, {mx[k], my[k]});
            if (k == 5) begin
                ld_valid = 1'b1;
                ld_idx   = 6'd0;
                ld_x     = ~keep_x0;
                ld_y     = ~keep_y0;
            end
            if (k == 6) ld_valid = 1'b0;
            if (k == 8) start = 1'b1;
            if (k == 9) start = 1'b0;
            if (k == 10) begin
                done = 1'b1;
                c1x = 4'hF; c1y = 4'hF; c2x = 4'hF; c2y = 4'hF;
            end
            if (k == 12) done = 1'b0;
        end
        @(posedge clk); #1;
        check("wait_xy_zero", {x, y}, 0);
        check("wait_busy", busy, 1);
        check("wait_lsr_rst", lsr_rst, 0);
        repeat (lat) @(posedge clk);
        #1;
        c1x = 4'(ax); c1y = 4'(ay); c2x = 4'(bx); c2y = 4'(by);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        c1x = 4'hA; c1y = 4'hA; c2x = 4'hA; c2y = 4'hA;
        check("cap_c1x", cap_c1x, ax);
        check("cap_c1y", cap_c1y, ay);
        check("cap_c2x", cap_c2x, bx);
        check("cap_c2y", cap_c2y, by);
        exp = ref_score(ax, ay, bx, by);
        for (int j = 0; j < 39; j++) begin
            if (j == 20) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("score_busy", busy, 1);
        check("score_not_valid_yet", res_valid, 0);
        check("score_lsr_rst", lsr_rst, 0);
        @(posedge clk); #1;
        check("res_valid", res_valid, 1);
        check("res_busy_low", busy, 0);
        check("res_score", score, exp);
        check("res_timeout_low", res_timeout, 0);
        repeat (3) @(posedge clk);
        #1;
        check("res_valid_held", res_valid, 1);
        check("res_score_held", score, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        int sx, sy;
        rst_n = 1'b0; ld_valid = 1'b0; ld_idx = '0; ld_x = '0; ld_y = '0;
        start = 1'b0; done = 1'b0;
        c1x = '0; c1y = '0; c2x = '0; c2y = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_lsr_rst", lsr_rst, 0);
        check("post_reset_busy", busy, 0);

        // All points at (5,5): full coverage.
        for (int i = 0; i < NP; i++) load_point(i, 5, 5);
        run_once(5, 5, 0, 0, 2);

        // dx=4/dy=0 is covered, dx=3/dy=3 is not.
        for (int i = 0; i < 20; i++) load_point(i, 9, 5);
        for (int i = 20; i < NP; i++) load_point(i, 8, 8);
        check("ref_edge_case", ref_score(5, 5, 5, 5), 20);
        run_once(5, 5, 5, 5, 4);

        // Out-of-range index is dropped; write coinciding with start is used.
        load_point(45, 1, 1);
        load_point(40, 2, 2);
        ld_valid = 1'b1; ld_idx = 6'd0; ld_x = 4'd7; ld_y = 4'd3;
        mx[0] = 4'd7; my[0] = 4'd3;
        run_once(7, 3, 12, 12, 1);

        // Randomised point sets and centres.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NP; i++)
                load_point(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            load_point(int'($urandom_range(40, 63)), 3, 3);
            sx = int'(mx[$urandom_range(0, NP - 1)]);
            sy = int'(my[$urandom_range(0, NP - 1)]);
            run_once(sx, sy, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(1, 20)));
        end

        // Asynchronous reset in SEND cycle 20.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("pre_abort_xy", {x, y}, {mx[20], my[20]});
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_abort_lsr_rst", lsr_rst, 0);
        for (int i = 0; i < NP; i++)
            load_point(i, int'($urandom_range(2, 10)), int'($urandom_range(2, 10)));
        run_once(6, 6, 3, 9, 5);

        // Core never answers.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (41) @(posedge clk);
        #1;
        check("nodone_in_wait", busy, 1);
`ifdef LASER_DRV_TIMEOUT_EN
        repeat (TB_TIMEOUT - 1) @(posedge clk);
        #1;
        check("wdog_not_yet", res_valid, 0);
        check("wdog_busy", busy, 1);
        @(posedge clk); #1;
        check("wdog_timeout", res_timeout, 1);
        check("wdog_valid", res_valid, 1);
        check("wdog_score", score, 0);
        check("wdog_busy_low", busy, 0);
        check("wdog_caps", {cap_c1x, cap_c1y, cap_c2x, cap_c2y}, 0);
`else
        repeat (200) @(posedge clk);
        #1;
        check("nodone_busy_held", busy, 1);
        check("nodone_no_valid", res_valid, 0);
        check("nodone_no_timeout", res_timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
